// File: rtl/me_sad_search.sv
// Full-search block-matching motion estimator: sweeps every candidate offset and reports min SAD + vector.
// Optional ME_EARLY_TERM_EN abandons a candidate once its running SAD reaches the best so far.
module me_sad_search #(
   parameter  int BLK   = 16,
   parameter  int RANGE = 8,
   parameter  int PIX_W = 8,
   localparam int SW    = BLK + 2*RANGE,
   localparam int RA_W  = $clog2(BLK*BLK),
   localparam int SA_W  = $clog2(SW*SW),
   localparam int SAD_W = PIX_W + 2*$clog2(BLK),
   localparam int MV_W  = $clog2(2*RANGE) + 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start_signal,
   output logic [RA_W-1:0]         addr_R,
   output logic [SA_W-1:0]         addr_S,
   input  logic [PIX_W-1:0]        R_val,
   input  logic [PIX_W-1:0]        S_val,
   output logic                    busy,
   output logic                    complete_signal,
   output logic [SAD_W-1:0]        best_distance,
   output logic signed [MV_W-1:0]  x_motion,
   output logic signed [MV_W-1:0]  y_motion
`ifdef ME_EARLY_TERM_EN
   ,
   output logic [15:0]             skip_count
`endif
);
   localparam int LB     = $clog2(BLK);
   localparam int CW     = $clog2(2*RANGE);
   localparam int CI_W   = 2*CW;
   localparam int STAGES = 2;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
   state_t state;

   logic [RA_W-1:0]                pix_cnt, sel_pix;
   logic [CI_W-1:0]                cand_cnt, sel_cand;
   logic [STAGES:0]                vld_pipe, first_pipe, last_pipe;
   logic [STAGES:0][CI_W-1:0]      cand_pipe;
   logic [PIX_W-1:0]               diff;
   logic [SAD_W-1:0]               acc, acc_next, best;
   logic [CI_W-1:0]                best_cand;
   logic                           have_best, take, abandon, jump, issue, start_acc, sel_last;
   logic                           kill1, kill2;
   logic [SA_W-1:0]                addr_s_nx;

   always_comb begin
      acc_next  = first_pipe[2] ? SAD_W'(diff) : acc + SAD_W'(diff);
      take      = vld_pipe[2] & last_pipe[2] & (~have_best | (acc_next < best));
`ifdef ME_EARLY_TERM_EN
      abandon   = vld_pipe[2] & ~last_pipe[2] & have_best & (acc_next >= best);
`else
      abandon   = 1'b0;
`endif
      // Jump only if the generator is still inside the candidate being abandoned
      jump      = abandon & (cand_cnt == cand_pipe[2]);
      kill1     = abandon & (cand_pipe[0] == cand_pipe[2]);
      kill2     = abandon & (cand_pipe[1] == cand_pipe[2]);
      sel_pix   = jump ? '0 : pix_cnt;
      sel_cand  = jump ? cand_cnt + CI_W'(1) : cand_cnt;
      sel_last  = &sel_pix;
      start_acc = (state == IDLE) & start_signal;
      issue     = start_acc | ((state == RUN) & ~(jump & (&cand_cnt)));
      addr_s_nx = (SA_W'(sel_cand[CI_W-1:CW]) + SA_W'(sel_pix[RA_W-1:LB])) * SA_W'(SW)
                + SA_W'(sel_cand[CW-1:0]) + SA_W'(sel_pix[LB-1:0]);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= IDLE;
         busy            <= 1'b0;
         complete_signal <= 1'b0;
         best_distance   <= '0;
         x_motion        <= '0;
         y_motion        <= '0;
         addr_R          <= '0;
         addr_S          <= '0;
         pix_cnt         <= '0;
         cand_cnt        <= '0;
         vld_pipe        <= '0;
         first_pipe      <= '0;
         last_pipe       <= '0;
         cand_pipe       <= '0;
      end else begin
         vld_pipe        <= {vld_pipe[1] & ~kill2, vld_pipe[0] & ~kill1, issue};
         first_pipe      <= {first_pipe[1:0], sel_pix == '0};
         last_pipe       <= {last_pipe[1:0], sel_last};
         cand_pipe[2]    <= cand_pipe[1];
         cand_pipe[1]    <= cand_pipe[0];
         complete_signal <= 1'b0;
         if (issue) begin
            addr_R       <= sel_pix;
            addr_S       <= addr_s_nx;
            pix_cnt      <= sel_pix + RA_W'(1);
            cand_cnt     <= sel_last ? sel_cand + CI_W'(1) : sel_cand;
            cand_pipe[0] <= sel_cand;
         end
         case (state)
            IDLE:  if (start_signal) begin
                      state <= RUN;
                      busy  <= 1'b1;
                   end
            // No issue while in RUN means the final candidate was abandoned
            RUN:   if (~issue | (sel_last & (&sel_cand))) state <= DRAIN;
            DRAIN: if (vld_pipe == '0) begin
                      state           <= DONE;
                      complete_signal <= 1'b1;
                      best_distance   <= best;
                      x_motion        <= {1'b0, best_cand[CW-1:0]} - MV_W'(RANGE);
                      y_motion        <= {1'b0, best_cand[CI_W-1:CW]} - MV_W'(RANGE);
                   end
            DONE:  begin
                      state    <= IDLE;
                      busy     <= 1'b0;
                      pix_cnt  <= '0;
                      cand_cnt <= '0;
                   end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         diff      <= '0;
         acc       <= '0;
         best      <= '0;
         best_cand <= '0;
         have_best <= 1'b0;
`ifdef ME_EARLY_TERM_EN
         skip_count <= '0;
`endif
      end else begin
         diff <= (R_val > S_val) ? R_val - S_val : S_val - R_val;
         if (vld_pipe[2]) acc <= acc_next;
         if (start_acc) have_best <= 1'b0;
         else if (take) begin
            best      <= acc_next;
            best_cand <= cand_pipe[2];
            have_best <= 1'b1;
         end
`ifdef ME_EARLY_TERM_EN
         if (start_acc) skip_count <= '0;
         else if (abandon && skip_count != '1) skip_count <= skip_count + 16'd1;
`endif
      end
   end
endmodule

// File: tb/tb_me_sad_search.sv
// Bench for me_sad_search at BLK=4, RANGE=2: random/directed windows checked against a plain SAD scan.
module tb_me_sad_search;
   localparam int BLK = 4, RANGE = 2, PIX_W = 8;
   localparam int SW = BLK + 2*RANGE, NPIX = BLK*BLK, NS = SW*SW, NCAND = (2*RANGE)*(2*RANGE);
   localparam int RA_W = $clog2(NPIX), SA_W = $clog2(NS), SAD_W = PIX_W + 2*$clog2(BLK);
   localparam int MV_W = $clog2(2*RANGE) + 1;
   localparam int LAT = NCAND*NPIX + 4;
   localparam int MAX_S = (2*RANGE-1 + BLK-1) * (SW + 1);

   logic clk = 1'b0, rst_n = 1'b0, start_signal = 1'b0;
   logic [RA_W-1:0] addr_R;
   logic [SA_W-1:0] addr_S;
   logic [PIX_W-1:0] R_val, S_val;
   logic busy, complete_signal;
   logic [SAD_W-1:0] best_distance;
   logic signed [MV_W-1:0] x_motion, y_motion;
`ifdef ME_EARLY_TERM_EN
   logic [15:0] skip_count;
`endif

   logic [PIX_W-1:0] R_mem [NPIX];
   logic [PIX_W-1:0] S_mem [NS];
   int checks = 0, failures = 0;

   me_sad_search #(.BLK(BLK), .RANGE(RANGE), .PIX_W(PIX_W)) dut (
      .clk(clk), .rst_n(rst_n), .start_signal(start_signal),
      .addr_R(addr_R), .addr_S(addr_S), .R_val(R_val), .S_val(S_val),
      .busy(busy), .complete_signal(complete_signal), .best_distance(best_distance),
      .x_motion(x_motion), .y_motion(y_motion)
`ifdef ME_EARLY_TERM_EN
      , .skip_count(skip_count)
`endif
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      R_val <= R_mem[addr_R];
      S_val <= S_mem[addr_S];
   end

   task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Straightforward scan over all candidates, earliest wins on ties
   task automatic model(output int bsad, output int bx, output int by);
      bsad = 0; bx = 0; by = 0;
      for (int cy = 0; cy < 2*RANGE; cy++)
         for (int cx = 0; cx < 2*RANGE; cx++) begin
            int sad, d;
            sad = 0;
            for (int i = 0; i < BLK; i++)
               for (int j = 0; j < BLK; j++) begin
                  d = int'(R_mem[i*BLK+j]) - int'(S_mem[(cy+i)*SW + cx+j]);
                  sad += (d < 0) ? -d : d;
               end
            if ((cx == 0 && cy == 0) || sad < bsad) begin
               bsad = sad; bx = cx - RANGE; by = cy - RANGE;
            end
         end
   endtask

   task automatic fill_rand();
      for (int k = 0; k < NPIX; k++) R_mem[k] = 8'($urandom_range(0, 255));
      for (int k = 0; k < NS; k++)   S_mem[k] = 8'($urandom_range(0, 255));
   endtask

   task automatic fill_const(input int r, input int s);
      for (int k = 0; k < NPIX; k++) R_mem[k] = 8'(r);
      for (int k = 0; k < NS; k++)   S_mem[k] = 8'(s);
   endtask

   task automatic place(input int mx, input int my);
      for (int i = 0; i < BLK; i++)
         for (int j = 0; j < BLK; j++)
            S_mem[(my+RANGE+i)*SW + mx+RANGE+j] = R_mem[i*BLK+j];
   endtask

   // Called at a negedge; leaves at the negedge after complete_signal
   task automatic run(input string tag, input int poke_at, output int cyc);
      int eb, ex, ey, mx;
      model(eb, ex, ey);
      start_signal = 1'b1;
      @(posedge clk);
      #1 start_signal = 1'b0;
      cyc = 0; mx = 0;
      do begin
         @(negedge clk);
         cyc++;
         start_signal = (cyc == poke_at);
         if (cyc == 1) chk({tag, ".busy_rise"}, busy, 1);
         if (int'(addr_S) > mx) mx = int'(addr_S);
      end while (complete_signal !== 1'b1 && cyc < 4*LAT);
      start_signal = 1'b0;
      chk({tag, ".done"}, complete_signal, 1);
`ifdef ME_EARLY_TERM_EN
      chk({tag, ".cycles_le"}, cyc <= LAT, 1);
`else
      chk({tag, ".cycles"}, cyc, LAT);
      chk({tag, ".max_addr_S"}, mx, MAX_S);
`endif
      chk({tag, ".best"}, best_distance, eb);
      chk({tag, ".x"}, x_motion, ex);
      chk({tag, ".y"}, y_motion, ey);
      @(negedge clk);
      chk({tag, ".done_fall"}, complete_signal, 0);
      chk({tag, ".busy_fall"}, busy, 0);
   endtask

   initial begin
      int cyc;
      fill_rand();
      #3;
      chk("rst.busy", busy, 0);
      chk("rst.done", complete_signal, 0);
      chk("rst.best", best_distance, 0);
      chk("rst.x", x_motion, 0);
      chk("rst.y", y_motion, 0);
      chk("rst.addr_R", addr_R, 0);
      chk("rst.addr_S", addr_S, 0);
      @(negedge clk) rst_n = 1'b1;
      @(negedge clk);

      fill_rand(); place(-2, 1);
      run("match_m2p1", 0, cyc);
      chk("match_m2p1.best_c", best_distance, 0);
      chk("match_m2p1.x_c", x_motion, -2);
      chk("match_m2p1.y_c", y_motion, 1);

      fill_const(10, 0);
      run("tie10", 0, cyc);
      chk("tie10.best_c", best_distance, 10*NPIX);

      fill_const(255, 0);
      run("sat255", 0, cyc);
      chk("sat255.best_c", best_distance, 255*NPIX);

      // Abort mid-search: previous result must not survive
      fill_rand();
      start_signal = 1'b1;
      @(posedge clk);
      #1 start_signal = 1'b0;
      repeat (100) @(negedge clk);
      chk("abort.busy_mid", busy, 1);
      rst_n = 1'b0;
      #1;
      chk("abort.busy", busy, 0);
      chk("abort.best", best_distance, 0);
      chk("abort.addr_S", addr_S, 0);
      chk("abort.x", x_motion, 0);
      @(negedge clk) rst_n = 1'b1;
      @(negedge clk);
      place(1, -1);
      run("after_rst", 0, cyc);

      for (int t = 0; t < 3; t++) begin
         fill_rand();
         run($sformatf("rand%0d", t), (t == 1) ? 50 : 0, cyc);
      end

      fill_rand(); place(-RANGE, -RANGE);
      run("match_first", 0, cyc);
`ifdef ME_EARLY_TERM_EN
      chk("match_first.fast", cyc < LAT, 1);
      chk("match_first.skip", skip_count, NCAND - 1);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
